// File: rtl/jt12_pg_pkg.sv
// Shared definitions for the FM phase generator: detune and PMS tables,
// the stage II register bundle and slot-count helpers.
package jt12_pg_pkg;

    localparam int PH_W = 17;  // phase increment width before the multiplier

    // Stage I results captured into stage II on each clk_en.
    typedef struct packed {
        logic [PH_W-1:0] phinc;
        logic [PH_W-1:0] det;     // two's complement detune
        logic [4:0]      keycode;
    } pg_stage2_t;

    // Detune magnitudes per keycode, one table per dt1 magnitude index 1..3.
    localparam logic [4:0] DT_TAB1 [32] = '{
        5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1,
        5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2,
        5'd2, 5'd3, 5'd3, 5'd3, 5'd4, 5'd4, 5'd4, 5'd5,
        5'd5, 5'd6, 5'd6, 5'd7, 5'd8, 5'd8, 5'd8, 5'd8
    };
    localparam logic [4:0] DT_TAB2 [32] = '{
        5'd1,  5'd1,  5'd1,  5'd1,  5'd2,  5'd2,  5'd2,  5'd2,
        5'd2,  5'd3,  5'd3,  5'd3,  5'd4,  5'd4,  5'd4,  5'd5,
        5'd5,  5'd6,  5'd6,  5'd7,  5'd8,  5'd8,  5'd9,  5'd10,
        5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd16, 5'd16, 5'd16
    };
    localparam logic [4:0] DT_TAB3 [32] = '{
        5'd2,  5'd2,  5'd2,  5'd2,  5'd2,  5'd3,  5'd3,  5'd3,
        5'd4,  5'd4,  5'd4,  5'd5,  5'd5,  5'd6,  5'd6,  5'd7,
        5'd8,  5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14,
        5'd16, 5'd17, 5'd19, 5'd20, 5'd22, 5'd22, 5'd22, 5'd22
    };

    // LFO phase-modulation depth multiplier per PMS setting; PMS=0 disables PM.
    localparam logic [4:0] PMS_DEPTH [8] = '{
        5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd8, 5'd16
    };

    function automatic int num_slots(input int ch, input int op);
        return ch * op;
    endfunction

    function automatic int slot_width(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

    // Unsigned detune magnitude; index 0 means no detune.
    function automatic logic [4:0] dt_lookup(input logic [4:0] kc, input logic [1:0] idx);
        logic [4:0] mag;
        case (idx)
            2'd1:    mag = DT_TAB1[kc];
            2'd2:    mag = DT_TAB2[kc];
            2'd3:    mag = DT_TAB3[kc];
            default: mag = 5'd0;
        endcase
        return mag;
    endfunction

endpackage

// File: rtl/jt12_pg_if.sv
// Register-file side bus of the phase generator: per-slot channel/operator
// parameters in, keycode / slot index / phase out.
interface jt12_pg_if #(
    parameter int SLOT_W = 5,
    parameter int OUT_W  = 10
);
    logic              clk_en;
    logic [10:0]       fnum_I;
    logic [2:0]        block_I;
    logic [2:0]        dt1_I;
    logic [2:0]        pms_I;
    logic [6:0]        lfo_mod;
    logic [3:0]        mul_II;
    logic              pg_rst_II;
    logic              pg_stop_II;
    logic [4:0]        keycode_II;
    logic [SLOT_W-1:0] slot_II;
    logic [OUT_W-1:0]  phase_out;

    modport master (
        output clk_en, fnum_I, block_I, dt1_I, pms_I, lfo_mod,
               mul_II, pg_rst_II, pg_stop_II,
        input  keycode_II, slot_II, phase_out
    );

    modport slave (
        input  clk_en, fnum_I, block_I, dt1_I, pms_I, lfo_mod,
               mul_II, pg_rst_II, pg_stop_II,
        output keycode_II, slot_II, phase_out
    );
endinterface

// File: rtl/jt12_pg_inc.sv
// Stage I of the phase generator, purely combinational: LFO-shifted
// F-number, octave shift to a 17-bit increment, keycode and detune.
module jt12_pg_inc
    import jt12_pg_pkg::*;
(
    input  logic [10:0]     i_fnum,
    input  logic [2:0]      i_block,
    input  logic [2:0]      i_dt1,
    input  logic [2:0]      i_pms,
    input  logic [6:0]      i_lfo_mod,
    output logic [PH_W-1:0] o_phinc,
    output logic [PH_W-1:0] o_det,
    output logic [4:0]      o_keycode
);
    logic [4:0]  w_depth;
    logic [17:0] w_pm_prod;
    logic [8:0]  w_pm_off;
    logic [11:0] w_fm;
    logic [4:0]  w_keycode;
    logic [4:0]  w_det_mag;

    // The PM offset scales with the upper F-number bits, so it never exceeds
    // the F-number itself and the downward shift cannot underflow.
    assign w_depth   = PMS_DEPTH[i_pms];
    assign w_pm_prod = 18'(i_fnum[10:4]) * 18'(i_lfo_mod[5:0]) * 18'(w_depth);
    assign w_pm_off  = 9'(w_pm_prod >> 9);
    assign w_fm      = i_lfo_mod[6] ? ({1'b0, i_fnum} - {3'b0, w_pm_off})
                                    : ({1'b0, i_fnum} + {3'b0, w_pm_off});

    // Octave scaling: block 7 keeps the full F-number, each lower block halves it.
    assign o_phinc = 17'(({w_fm, 7'b0} >> (3'd7 - i_block)) >> 1);

    assign w_keycode = {i_block, i_fnum[10],
                        (i_fnum[10] & (|i_fnum[9:7])) | (~i_fnum[10] & (&i_fnum[9:7]))};
    assign o_keycode = w_keycode;

    assign w_det_mag = dt_lookup(w_keycode, i_dt1[1:0]);
    assign o_det     = i_dt1[2] ? (17'd0 - {12'd0, w_det_mag}) : {12'd0, w_det_mag};

endmodule

// File: rtl/jt12_pg_gen.sv
// Time-multiplexed FM phase generator: one slot per clk_en, stage I math,
// stage II multiplier, a ring of per-slot accumulators and an output delay line.
module jt12_pg_gen
    import jt12_pg_pkg::*;
#(
    parameter int NUM_CH  = 6,
    parameter int NUM_OP  = 4,
    parameter int ACC_W   = 20,
    parameter int OUT_W   = 10,
    parameter int OUT_DLY = 6
) (
    input logic      clk,
    input logic      rst,
    jt12_pg_if.slave pg
);
    localparam int SLOTS  = num_slots(NUM_CH, NUM_OP);
    localparam int SLOT_W = slot_width(SLOTS);

    logic [PH_W-1:0]   w_phinc_I;
    logic [PH_W-1:0]   w_det_I;
    logic [4:0]        w_keycode_I;
    pg_stage2_t        r_st2;
    logic [SLOT_W-1:0] r_slot_II;
    logic [PH_W-1:0]   w_pd;
    logic [ACC_W-1:0]  w_inc;
    logic [ACC_W-1:0]  w_old;
    logic [ACC_W-1:0]  w_new;
    logic [OUT_W-1:0]  w_phase_II;
    logic [ACC_W-1:0]  r_ring      [SLOTS];
    logic [ACC_W-1:0]  w_ring_next [SLOTS];
    logic [OUT_W-1:0]  r_dly       [OUT_DLY];
    logic [OUT_W-1:0]  w_dly_next  [OUT_DLY];

    jt12_pg_inc u_inc (
        .i_fnum    (pg.fnum_I),
        .i_block   (pg.block_I),
        .i_dt1     (pg.dt1_I),
        .i_pms     (pg.pms_I),
        .i_lfo_mod (pg.lfo_mod),
        .o_phinc   (w_phinc_I),
        .o_det     (w_det_I),
        .o_keycode (w_keycode_I)
    );

    // Stage I -> II pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st2 <= '0;
        end else if (pg.clk_en) begin
            r_st2.phinc   <= w_phinc_I;
            r_st2.det     <= w_det_I;
            r_st2.keycode <= w_keycode_I;
        end
    end

    // Slot counter naming the slot currently in stage II.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_II <= '0;
        end else if (pg.clk_en) begin
            r_slot_II <= (r_slot_II == SLOT_W'(SLOTS - 1)) ? '0 : r_slot_II + SLOT_W'(1);
        end
    end

    // Stage II: detuned increment, multiplier (0 means x1/2), then the
    // accumulator update. Reset of the slot beats stop.
    assign w_pd  = r_st2.phinc + r_st2.det;
    assign w_inc = (pg.mul_II == 4'd0) ? ACC_W'(w_pd >> 1)
                                       : ACC_W'(w_pd) * ACC_W'(pg.mul_II);
    assign w_old = r_ring[SLOTS-1];
    assign w_new = pg.pg_rst_II  ? '0    :
                   pg.pg_stop_II ? w_old : w_old + w_inc;
    assign w_phase_II = w_new[ACC_W-1 -: OUT_W];

    // Ring and delay-line shift paths; element 0 takes the new value.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_ring
            if (gi == 0) begin : g_head
                assign w_ring_next[gi] = w_new;
            end else begin : g_body
                assign w_ring_next[gi] = r_ring[gi-1];
            end
        end
        for (gi = 0; gi < OUT_DLY; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign w_dly_next[gi] = w_phase_II;
            end else begin : g_body
                assign w_dly_next[gi] = r_dly[gi-1];
            end
        end
    endgenerate

    // Advance the accumulator ring; the tail entry always belongs to slot_II.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ring <= '{default: '0};
        end else if (pg.clk_en) begin
            r_ring <= w_ring_next;
        end
    end

    // Output delay line aligning phase_out with the downstream operator stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= '{default: '0};
        end else if (pg.clk_en) begin
            r_dly <= w_dly_next;
        end
    end

    assign pg.keycode_II = r_st2.keycode;
    assign pg.slot_II    = r_slot_II;
    assign pg.phase_out  = r_dly[OUT_DLY-1];

endmodule

// File: tb/tb_jt12_pg_gen.sv
// Directed bench for jt12_pg_gen: keycode vector table, multiplier table,
// per-step model checks of phase_out/slot_II and hand-computed visit values.
module tb_jt12_pg_gen;
    localparam int SLOTS    = 24;
    localparam int ACC_W    = 20;
    localparam int OUT_W    = 10;
    localparam int OUT_DLY  = 6;
    localparam int ACC_MASK = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jt12_pg_if #(.SLOT_W(5), .OUT_W(OUT_W)) pg_bus ();

    jt12_pg_gen #(
        .NUM_CH(6), .NUM_OP(4), .ACC_W(ACC_W), .OUT_W(OUT_W), .OUT_DLY(OUT_DLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pg  (pg_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    int m_acc    [SLOTS];
    int m_visits [SLOTS];
    int m_pipe   [OUT_DLY];
    int m_pslot  [OUT_DLY];
    int m_slot;
    int m_pd_I;
    int m_pd_II;
    int m_mul;
    bit chk_on;

    // Flagged slot control
    int flag_slot = -1;
    int flag_visit, flag_n;
    bit flag_stop, flag_rst;

    // Observations of the tracked slot, one per visit
    int trk_slot;
    int obs [256];
    int n_obs;

    typedef struct {
        logic [10:0] fnum;
        logic [2:0]  block;
        int          kc;
    } kc_vec_t;
    kc_vec_t kv [7];

    typedef struct {
        int mul;
        int e0;
        int e1;
    } mul_vec_t;
    mul_vec_t mv [3];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int calc_inc(input int pd, input int mul);
        return (mul == 0) ? (pd >> 1) : ((pd * mul) & ACC_MASK);
    endfunction

    task automatic model_edge(input bit en, input bit r, input bit f_stop, input bit f_rst);
        int old_v, new_v;
        if (r) begin
            for (int i = 0; i < SLOTS; i++) begin
                m_acc[i] = 0;
                m_visits[i] = 0;
            end
            for (int i = 0; i < OUT_DLY; i++) begin
                m_pipe[i] = 0;
                m_pslot[i] = -1;
            end
            m_slot = 0;
            m_pd_II = 0;
        end else if (en) begin
            old_v = m_acc[m_slot];
            if (f_rst)       new_v = 0;
            else if (f_stop) new_v = old_v;
            else             new_v = (old_v + calc_inc(m_pd_II, m_mul)) & ACC_MASK;
            m_acc[m_slot] = new_v;
            for (int i = OUT_DLY - 1; i > 0; i--) begin
                m_pipe[i] = m_pipe[i-1];
                m_pslot[i] = m_pslot[i-1];
            end
            m_pipe[0] = new_v >> (ACC_W - OUT_W);
            m_pslot[0] = m_slot;
            m_visits[m_slot]++;
            m_slot = (m_slot + 1) % SLOTS;
            m_pd_II = m_pd_I;
        end
    endtask

    // One clock: drive inputs, take the edge, compare 1 time unit later.
    task automatic step(input bit en, input bit r);
        bit f_act;
        f_act = 1'b0;
        if (flag_slot >= 0 && m_slot == flag_slot &&
            m_visits[flag_slot] >= flag_visit && m_visits[flag_slot] < flag_visit + flag_n)
            f_act = 1'b1;
        pg_bus.clk_en     = en;
        rst               = r;
        pg_bus.pg_stop_II = f_act & flag_stop;
        pg_bus.pg_rst_II  = f_act & flag_rst;
        @(posedge clk);
        model_edge(en, r, f_act & flag_stop, f_act & flag_rst);
        #1;
        rst = 1'b0;
        if (chk_on) begin
            check("phase_out", int'(pg_bus.phase_out), m_pipe[OUT_DLY-1]);
            check("slot_II", int'(pg_bus.slot_II), m_slot);
            if (en && !r && m_pslot[OUT_DLY-1] == trk_slot && n_obs < 256) begin
                obs[n_obs] = int'(pg_bus.phase_out);
                n_obs++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic reset_track(input int slot);
        trk_slot = slot;
        n_obs = 0;
        step(1'b1, 1'b1);
        check("rst_phase", int'(pg_bus.phase_out), 0);
        check("rst_slot", int'(pg_bus.slot_II), 0);
    endtask

    task automatic check_obs(input string name, input int idx, input int exp);
        check($sformatf("%s[%0d]", name, idx), (idx < n_obs) ? obs[idx] : -1, exp);
    endtask

    task automatic set_mul(input int mul);
        m_mul = mul;
        pg_bus.mul_II = 4'(mul);
    endtask

    initial begin
        kv[0] = '{11'h400, 3'd4, 18};
        kv[1] = '{11'h480, 3'd4, 19};
        kv[2] = '{11'h380, 3'd2, 9};
        kv[3] = '{11'h300, 3'd7, 28};
        kv[4] = '{11'h7FF, 3'd7, 31};
        kv[5] = '{11'h000, 3'd0, 0};
        kv[6] = '{11'h080, 3'd3, 12};
        mv[0] = '{0, 4, 8};
        mv[1] = '{3, 24, 48};
        mv[2] = '{15, 120, 240};

        pg_bus.fnum_I  = 11'h400;
        pg_bus.block_I = 3'd4;
        pg_bus.dt1_I   = 3'd0;
        pg_bus.pms_I   = 3'd0;
        pg_bus.lfo_mod = 7'd0;
        set_mul(1);
        m_pd_I   = 8192;
        trk_slot = -1;
        n_obs    = 0;
        chk_on   = 1'b0;

        // Reset with clk_en low clears everything.
        step(1'b0, 1'b1);
        check("reset_phase_out", int'(pg_bus.phase_out), 0);
        check("reset_slot_II", int'(pg_bus.slot_II), 0);
        check("reset_keycode", int'(pg_bus.keycode_II), 0);

        // Keycode vectors.
        for (int i = 0; i < 7; i++) begin
            pg_bus.fnum_I  = kv[i].fnum;
            pg_bus.block_I = kv[i].block;
            step(1'b1, 1'b0);
            check($sformatf("keycode_vec%0d", i), int'(pg_bus.keycode_II), kv[i].kc);
        end
        pg_bus.fnum_I  = 11'h400;
        pg_bus.block_I = 3'd4;
        chk_on = 1'b1;

        // Plain increment, mul=1: 8 per visit, wraps after 128 visits.
        reset_track(3);
        run(SLOTS * 130);
        check_obs("inc", 0, 8);
        check_obs("inc", 1, 16);
        check_obs("inc", 2, 24);
        check_obs("inc", 126, 1016);
        check_obs("inc", 127, 0);
        check_obs("inc", 128, 8);

        // Multiplier table.
        for (int i = 0; i < 3; i++) begin
            set_mul(mv[i].mul);
            reset_track(3);
            run(SLOTS * 4);
            check_obs($sformatf("mul%0d", mv[i].mul), 0, mv[i].e0);
            check_obs($sformatf("mul%0d", mv[i].mul), 1, mv[i].e1);
        end
        set_mul(1);

        // Negative detune: keycode 18, dt1=3 -> -9, increment 8183.
        pg_bus.dt1_I = 3'd7;
        m_pd_I = 8183;
        reset_track(3);
        run(SLOTS * 4);
        check_obs("det_neg", 0, 7);
        check_obs("det_neg", 1, 15);
        check_obs("det_neg", 2, 23);
        pg_bus.dt1_I = 3'd0;
        m_pd_I = 8192;

        // pg_stop on slot 5 after 10 visits, for 3 visits.
        flag_slot = 5; flag_visit = 10; flag_n = 3; flag_stop = 1'b1; flag_rst = 1'b0;
        reset_track(5);
        run(SLOTS * 16);
        check_obs("stop", 9, 80);
        check_obs("stop", 10, 80);
        check_obs("stop", 12, 80);
        check_obs("stop", 13, 88);
        check_obs("stop", 14, 96);

        // pg_rst and pg_stop together on slot 2: reset wins.
        flag_slot = 2; flag_visit = 3; flag_n = 1; flag_stop = 1'b1; flag_rst = 1'b1;
        reset_track(2);
        run(SLOTS * 7);
        check_obs("rst_stop", 2, 24);
        check_obs("rst_stop", 3, 0);
        check_obs("rst_stop", 4, 8);
        check_obs("rst_stop", 5, 16);

        // clk_en low for 50 clocks with hostile inputs: nothing may move.
        flag_slot = m_slot; flag_visit = 0; flag_n = 100000; flag_stop = 1'b0; flag_rst = 1'b1;
        pg_bus.mul_II  = 4'd7;
        pg_bus.fnum_I  = 11'h7FF;
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
        flag_slot = -1;
        pg_bus.fnum_I = 11'h400;
        set_mul(1);
        run(SLOTS * 2);

        // Reset in the middle of a run.
        reset_track(3);
        check("midrst_keycode", int'(pg_bus.keycode_II), 0);
        run(SLOTS * 3);
        check_obs("midrst", 0, 8);
        check_obs("midrst", 1, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
